// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    ERROR
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int FETCH_LATENCY  = 2;

endpackage

// File: rtl/imem_stream_loader_if.sv
// Stream-in and CPU-fetch signal bundle; slave side is the loader, master side the source/CPU.
interface imem_stream_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) ();
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [31:0]           in_addr;
  logic                  in_done;
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_valid;

  modport slave (
    input  in_valid, in_data, in_addr, in_done, fetch_en, fetch_addr,
    output fetch_data, fetch_valid
  );

  modport master (
    output in_valid, in_data, in_addr, in_done, fetch_en, fetch_addr,
    input  fetch_data, fetch_valid
  );
endinterface

// File: rtl/imem_dp_ram.sv
// Simple dual-port RAM: write port A, two-stage registered read port B (BRAM with output register).
module imem_dp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_p0;
  logic                  re_p0;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Stage 0: array read
  always_ff @(posedge clk) begin
    if (re) rd_p0 <= mem[raddr];
  end

  // Stage 1: output register, holds its value when no read is in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      re_p0 <= 1'b0;
      rdata <= '0;
    end else begin
      re_p0 <= re;
      if (re_p0) rdata <= rd_p0;
    end
  end
endmodule

// File: rtl/imem_stream_loader.sv
// Loads a contiguous instruction stream into a dual-port IMEM, then releases the CPU and serves fetches.
// Optional IMEM_LOADER_CHECKSUM_EN adds a running sum of accepted words on port checksum.
module imem_stream_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DEPTH         = 64,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  imem_stream_loader_if.slave   bus,
  output logic                  cpu_rst_n,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);
  localparam logic [ADDR_WIDTH:0] DEPTH_W     = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [3:0]          SETTLE_LAST = 4'(RELEASE_DELAY - 1);

  generate
    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("DEPTH must equal 2**ADDR_WIDTH");
    end
    if (RELEASE_DELAY < 1 || RELEASE_DELAY > 15) begin : g_bad_delay
      $error("RELEASE_DELAY must be in 1..15");
    end
    if (FETCH_LATENCY != 2) begin : g_bad_lat
      $error("fetch pipeline is built for a latency of 2");
    end
  endgenerate

  state_t     state, state_nx;
  logic [3:0] settle_cnt, settle_cnt_nx;
  logic       addr_ok, accept, rd_en;
  logic       vld_p0, vld_p1;

  // Full-width compare catches addresses beyond DEPTH; the count guard rejects a 65th word.
  assign addr_ok = (bus.in_addr == 32'(word_count)) && (word_count < DEPTH_W);

  always_comb begin
    state_nx      = state;
    settle_cnt_nx = settle_cnt;
    accept        = 1'b0;
    unique case (state)
      IDLE, LOAD: begin
        if (bus.in_valid) begin
          if (addr_ok) begin
            accept   = 1'b1;
            state_nx = bus.in_done ? SETTLE : LOAD;
          end else begin
            state_nx = ERROR;
          end
        end else if (bus.in_done) begin
          state_nx = (state == IDLE) ? ERROR : SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nx      = RUN;
          settle_cnt_nx = '0;
        end else begin
          settle_cnt_nx = settle_cnt + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      word_count <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_cnt_nx;
      if (accept) word_count <= word_count + (ADDR_WIDTH+1)'(1);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      checksum <= '0;
    else if (accept) checksum <= checksum + bus.in_data;
  end
`endif

  assign cpu_rst_n  = (state == RUN);
  assign load_done  = (state == RUN);
  assign load_error = (state == ERROR);
  assign load_busy  = (state == IDLE) || (state == LOAD) || (state == SETTLE);

  assign rd_en = bus.fetch_en && (state == RUN);

  // Stage boundary: valid tracks the two RAM read stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= rd_en;
      vld_p1 <= vld_p0;
    end
  end

  assign bus.fetch_valid = vld_p1;

  imem_dp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (accept),
    .waddr(bus.in_addr[ADDR_WIDTH-1:0]),
    .wdata(bus.in_data),
    .re   (rd_en),
    .raddr(bus.fetch_addr),
    .rdata(bus.fetch_data)
  );
endmodule

// File: tb/tb_imem_stream_loader.sv
// Scenario bench for imem_stream_loader: load/fetch, faults, reset-reload and fetch gating.
module tb_imem_stream_loader;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_rst_n, load_busy, load_done, load_error;
  logic [6:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model [64];
  logic [31:0] exp_q [$];
  logic [31:0] sum_exp;

  always #5 clk = ~clk;

  imem_stream_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus ();

  imem_stream_loader #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(64), .RELEASE_DELAY(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cpu_rst_n (cpu_rst_n),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_error(load_error),
    .word_count(word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.in_valid = 1'b0; bus.in_done = 1'b0; bus.in_addr = '0; bus.in_data = '0;
    bus.fetch_en = 1'b0; bus.fetch_addr = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sum_exp = '0;
    exp_q.delete();
  endtask

  // One stream word for one cycle; the model tracks what the DUT should hold if accepted.
  task automatic send_word(input int addr, input logic [31:0] data, input logic done, input logic good);
    bus.in_valid = 1'b1; bus.in_addr = 32'(addr); bus.in_data = data; bus.in_done = done;
    if (good) begin
      model[addr[5:0]] = data;
      sum_exp = sum_exp + data;
    end
    tick();
    bus.in_valid = 1'b0; bus.in_done = 1'b0;
  endtask

  task automatic wait_run();
    int k;
    k = 0;
    while (!load_done && k < 50) begin
      tick();
      k++;
    end
    n_cmp++;
    if (load_done !== 1'b1) begin
      n_err++;
      $display("FAIL wait_run: load_done=%b required 1 within 50 cycles", load_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_done = 1'b0; bus.fetch_en = 1'b0;
    bus.in_addr = '0; bus.in_data = '0; bus.fetch_addr = '0;
    tick();
    tick();
    n_cmp++;
    if ({cpu_rst_n, load_busy, load_done, load_error, bus.fetch_valid} !== 5'b01000 ||
        word_count !== 7'd0 || bus.fetch_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset: rst/busy/done/err/fv=%b%b%b%b%b wc=%0d fd=%h required 01000 wc=0 fd=0",
               cpu_rst_n, load_busy, load_done, load_error, bus.fetch_valid, word_count, bus.fetch_data);
    end
    rst_n = 1'b1;
    sum_exp = '0;
  endtask

  task automatic test_nominal();
    apply_reset();
    for (int i = 0; i < 28; i++) send_word(i, 32'hA500_0000 + 32'(i), 1'b0, 1'b1);
    bus.in_done = 1'b1;
    tick();
    bus.in_done = 1'b0;
    n_cmp++;
    if (word_count !== 7'd28 || load_busy !== 1'b1 || cpu_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_settle: wc=%0d busy=%b cpu_rst_n=%b required 28 1 0", word_count, load_busy, cpu_rst_n);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++;
      if (cpu_rst_n !== (k == 4)) begin
        n_err++;
        $display("FAIL release_delay: cycle %0d cpu_rst_n=%b required %b", k, cpu_rst_n, (k == 4));
      end
    end
    n_cmp++;
    if (load_done !== 1'b1 || load_busy !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_run: done=%b busy=%b required 1 0", load_done, load_busy);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    n_cmp++;
    if (checksum !== sum_exp) begin
      n_err++;
      $display("FAIL nominal_checksum: %h required %h", checksum, sum_exp);
    end
`endif
    bus.fetch_en = 1'b1; bus.fetch_addr = 6'd5;
    exp_q.push_back(model[5]);
    tick();
    bus.fetch_en = 1'b0;
    n_cmp++;
    if (bus.fetch_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_latency_early: fetch_valid=%b required 0 at t+1", bus.fetch_valid);
    end
    tick();
    n_cmp++;
    if (bus.fetch_valid !== 1'b1 || exp_q.size() == 0 || bus.fetch_data !== exp_q[0]) begin
      n_err++;
      $display("FAIL fetch_addr5: valid=%b data=%h required 1 %h", bus.fetch_valid, bus.fetch_data, 32'hA500_0005);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic test_gap_fault();
    logic bad_rel;
    apply_reset();
    send_word(0, 32'h1111_0000, 1'b0, 1'b1);
    send_word(1, 32'h1111_0001, 1'b0, 1'b1);
    send_word(3, 32'h1111_0003, 1'b0, 1'b0);
    n_cmp++;
    if (load_error !== 1'b1 || word_count !== 7'd2 || load_busy !== 1'b0 || cpu_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL gap_fault: err=%b wc=%0d busy=%b cpu_rst_n=%b required 1 2 0 0",
               load_error, word_count, load_busy, cpu_rst_n);
    end
    bad_rel = 1'b0;
    for (int k = 0; k < 100; k++) begin
      bus.in_done = (k == 10);
      bus.in_valid = (k == 20); bus.in_addr = 32'd2;
      tick();
      if (cpu_rst_n !== 1'b0 || load_error !== 1'b1) bad_rel = 1'b1;
    end
    bus.in_done = 1'b0; bus.in_valid = 1'b0;
    n_cmp++;
    if (bad_rel !== 1'b0 || word_count !== 7'd2) begin
      n_err++;
      $display("FAIL gap_sticky: released/cleared=%b wc=%0d required 0 2", bad_rel, word_count);
    end
  endtask

  task automatic test_empty_image();
    apply_reset();
    bus.in_done = 1'b1;
    tick();
    bus.in_done = 1'b0;
    n_cmp++;
    if (load_error !== 1'b1 || word_count !== 7'd0 || cpu_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL empty_image: err=%b wc=%0d cpu_rst_n=%b required 1 0 0", load_error, word_count, cpu_rst_n);
    end
  endtask

  task automatic test_last_with_done();
    int k;
    apply_reset();
    for (int i = 0; i < 27; i++) send_word(i, 32'h3C00_0000 ^ (32'(i) * 32'h0101_0107), 1'b0, 1'b1);
    send_word(27, 32'hDEAD_BEEF, 1'b1, 1'b1);
    n_cmp++;
    if (word_count !== 7'd28 || load_busy !== 1'b1 || load_error !== 1'b0 || load_done !== 1'b0) begin
      n_err++;
      $display("FAIL last_with_done: wc=%0d busy=%b err=%b done=%b required 28 1 0 0",
               word_count, load_busy, load_error, load_done);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    n_cmp++;
    if (checksum !== sum_exp) begin
      n_err++;
      $display("FAIL last_checksum: %h required %h", checksum, sum_exp);
    end
`endif
    k = 0;
    while (!load_done && k < 10) begin tick(); k++; end
    n_cmp++;
    if (k !== 4) begin
      n_err++;
      $display("FAIL last_settle_len: %0d cycles required 4", k);
    end
    bus.fetch_en = 1'b1; bus.fetch_addr = 6'd27;
    exp_q.push_back(model[27]);
    tick();
    bus.fetch_en = 1'b0;
    tick();
    n_cmp++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== exp_q[0]) begin
      n_err++;
      $display("FAIL fetch_addr27: valid=%b data=%h required 1 %h", bus.fetch_valid, bus.fetch_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    for (int i = 0; i < 10; i++) send_word(i, 32'h0BAD_0000 + 32'(i), 1'b0, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sum_exp = '0;
    n_cmp++;
    if (word_count !== 7'd0 || load_busy !== 1'b1 || load_error !== 1'b0 || bus.fetch_data !== 32'd0) begin
      n_err++;
      $display("FAIL mid_reset: wc=%0d busy=%b err=%b fd=%h required 0 1 0 0",
               word_count, load_busy, load_error, bus.fetch_data);
    end
    for (int i = 0; i < 28; i++) send_word(i, 32'h5A00_0000 + 32'(i * 3), (i == 27), 1'b1);
    wait_run();
    bus.fetch_en = 1'b1; bus.fetch_addr = 6'd9;
    exp_q.push_back(model[9]);
    tick();
    bus.fetch_en = 1'b0;
    tick();
    n_cmp++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== exp_q[0]) begin
      n_err++;
      $display("FAIL reload_addr9: valid=%b data=%h required 1 %h", bus.fetch_valid, bus.fetch_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_fetch_gating();
    logic        early_vld;
    logic [31:0] got;
    apply_reset();
    early_vld = 1'b0;
    for (int i = 0; i < 28; i++) begin
      bus.fetch_en = i[0]; bus.fetch_addr = 6'(i);
      send_word(i, 32'hC0DE_0000 | 32'(i << 4), (i == 27), 1'b1);
      if (bus.fetch_valid !== 1'b0) early_vld = 1'b1;
    end
    bus.fetch_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.fetch_valid !== 1'b0) early_vld = 1'b1;
    end
    n_cmp++;
    if (early_vld !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_gating: fetch_valid seen=%b before RUN required 0", early_vld);
    end
    wait_run();
    for (int c = 0; c < 8; c++) begin
      bus.fetch_en = (c < 4); bus.fetch_addr = 6'(c);
      if (c < 4) exp_q.push_back(model[c]);
      tick();
      n_cmp++;
      if (bus.fetch_valid !== (c + 1 >= 2 && c + 1 <= 5)) begin
        n_err++;
        $display("FAIL burst_valid: cycle %0d fetch_valid=%b required %b", c + 1, bus.fetch_valid, (c + 1 >= 2 && c + 1 <= 5));
      end
      if (bus.fetch_valid === 1'b1) begin
        got = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_cmp++;
        if (bus.fetch_data !== got) begin
          n_err++;
          $display("FAIL burst_data: cycle %0d data=%h required %h", c + 1, bus.fetch_data, got);
        end
      end
    end
    bus.fetch_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || bus.fetch_data !== model[3]) begin
      n_err++;
      $display("FAIL burst_hold: pending=%0d data=%h required 0 %h", exp_q.size(), bus.fetch_data, model[3]);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gap_fault();
    test_empty_image();
    test_last_with_done();
    test_reset_mid_load();
    test_fetch_gating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
